prco_lsu: RTL and testbench

Memory/writeback stage directly downstream of the PRCO ALU.
- Consumes the ALU result, the RAM/register stage-enables and the branch flag.
- Performs LW/SW through a req/ack RAM port, then drives register-file writeback and PC redirect.
- Holds q_busy so fetch/decode/ALU stall while a RAM access is outstanding.

---
 rtl/prco_lsu_pkg.sv | 31 +++
 rtl/prco_lsu_timeout.sv | 27 ++
 rtl/prco_lsu.sv | 160 ++++++++++++++++
 tb/tb_prco_lsu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/prco_lsu_pkg.sv
// Shared definitions for the PRCO load/store/writeback stage: FSM encoding,
// PRCO opcodes, MMIO window base and the timeout default.
package prco_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } lsu_state_t;

  localparam logic [4:0] PRCO_OP_NOP = 5'd0;
  localparam logic [4:0] PRCO_OP_ADD = 5'd1;
  localparam logic [4:0] PRCO_OP_SUB = 5'd2;
  localparam logic [4:0] PRCO_OP_AND = 5'd3;
  localparam logic [4:0] PRCO_OP_OR  = 5'd4;
  localparam logic [4:0] PRCO_OP_XOR = 5'd5;
  localparam logic [4:0] PRCO_OP_CMP = 5'd8;
  localparam logic [4:0] PRCO_OP_JMP = 5'd10;
  localparam logic [4:0] PRCO_OP_LW  = 5'd16;
  localparam logic [4:0] PRCO_OP_SW  = 5'd17;

  localparam logic [15:0] LSU_MMIO_BASE       = 16'hFF00;
  localparam int          LSU_MEM_TIMEOUT_DEF = 255;

  // Ops whose ALU result is never written to the register file.
  function automatic logic wb_suppressed(input logic [4:0] op);
    return (op == PRCO_OP_CMP) || (op == PRCO_OP_JMP) ||
           (op == PRCO_OP_NOP) || (op == PRCO_OP_SW);
  endfunction

endpackage

// File: rtl/prco_lsu_timeout.sv
// Saturating 8-bit RAM-wait counter; q_expire flags the cycle in which the
// LIMIT-th enabled cycle is being counted.
module prco_lsu_timeout #(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic q_expire
);

  logic [7:0] count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= 8'd0;
    end else if (i_load) begin
      count_q <= 8'd0;
    end else if (i_en && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign q_expire = i_en && (count_q >= 8'(LIMIT - 1));

endmodule

// File: rtl/prco_lsu.sv
// PRCO memory/writeback stage: LW/SW over a req/ack RAM port, register
// writeback and PC redirect. `define PRCO_LSU_MMIO_EN adds a 16-entry bank at 0xFF00.
module prco_lsu
  import prco_lsu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_SEL_W   = 3,
  parameter int MEM_TIMEOUT = LSU_MEM_TIMEOUT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ce_ram,
  input  logic                 i_ce_reg,
  input  logic                 i_should_branch,
  input  logic [4:0]           i_op,
  input  logic [DATA_W-1:0]    i_alu_result,
  input  logic [DATA_W-1:0]    i_store_data,
  input  logic [REG_SEL_W-1:0] i_rd,
  output logic                 q_mem_req,
  output logic                 q_mem_we,
  output logic [DATA_W-1:0]    q_mem_addr,
  output logic [DATA_W-1:0]    q_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic                 q_wb_en,
  output logic [REG_SEL_W-1:0] q_wb_reg,
  output logic [DATA_W-1:0]    q_wb_data,
  output logic                 q_branch,
  output logic [DATA_W-1:0]    q_branch_target,
  output logic                 q_busy,
  output logic                 q_fault,
  output logic [1:0]           q_dbg_state
);

  // RAM handshake: q_mem_req rises with the request and stays high, with
  // address/wdata/we frozen, until the cycle i_mem_ack is sampled (or timeout).

  lsu_state_t           state_q, state_d;
  logic                 tmo_expire;
  logic                 wb_set, br_set, fault_set;
  logic [REG_SEL_W-1:0] wb_reg_d;
  logic [DATA_W-1:0]    wb_data_d;
  logic [REG_SEL_W-1:0] rd_q;
  logic                 accept_ram;

  assign accept_ram = (state_q == ST_IDLE) && i_ce_ram;

`ifdef PRCO_LSU_MMIO_EN
  logic              mmio_hit;
  logic              mmio_we;
  logic [DATA_W-1:0] mmio_rdata;
  logic [DATA_W-1:0] mmio_bank [16];

  assign mmio_hit   = (i_alu_result >= DATA_W'(LSU_MMIO_BASE));
  assign mmio_rdata = mmio_bank[i_alu_result[3:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++) mmio_bank[i] <= '0;
    end else if (mmio_we) begin
      mmio_bank[i_alu_result[3:0]] <= i_store_data;
    end
  end
`endif

  prco_lsu_timeout #(.LIMIT(MEM_TIMEOUT)) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (accept_ram),
    .i_en     (state_q == ST_REQ),
    .q_expire (tmo_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wb_set    = 1'b0;
    br_set    = 1'b0;
    fault_set = 1'b0;
    wb_reg_d  = i_rd;
    wb_data_d = i_alu_result;
`ifdef PRCO_LSU_MMIO_EN
    mmio_we   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_ce_ram) begin
`ifdef PRCO_LSU_MMIO_EN
          if (mmio_hit) begin
            if (i_op == PRCO_OP_SW) begin
              mmio_we = 1'b1;
            end else begin
              state_d   = ST_WB;
              wb_set    = 1'b1;
              wb_data_d = mmio_rdata;
            end
          end else
`endif
          state_d = ST_REQ;
        end else begin
          wb_set = i_ce_reg && !wb_suppressed(i_op);
          br_set = i_should_branch;
        end
      end
      ST_REQ: begin
        wb_reg_d  = rd_q;
        wb_data_d = i_mem_rdata;
        // Ack wins over a timeout expiring on the same cycle.
        if (i_mem_ack) begin
          state_d = q_mem_we ? ST_IDLE : ST_WB;
          wb_set  = !q_mem_we;
        end else if (tmo_expire) begin
          state_d   = ST_IDLE;
          fault_set = 1'b1;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_mem_we        <= 1'b0;
      q_mem_addr      <= '0;
      q_mem_wdata     <= '0;
      rd_q            <= '0;
      q_wb_en         <= 1'b0;
      q_wb_reg        <= '0;
      q_wb_data       <= '0;
      q_branch        <= 1'b0;
      q_branch_target <= '0;
      q_fault         <= 1'b0;
    end else begin
      if (accept_ram) begin
        q_mem_addr  <= i_alu_result;
        q_mem_wdata <= i_store_data;
        q_mem_we    <= (i_op == PRCO_OP_SW);
        rd_q        <= i_rd;
      end
      q_wb_en <= wb_set;
      if (wb_set) begin
        q_wb_reg  <= wb_reg_d;
        q_wb_data <= wb_data_d;
      end
      q_branch <= br_set;
      if (br_set) q_branch_target <= i_alu_result;
      q_fault <= fault_set;
    end
  end

  assign q_mem_req   = (state_q == ST_REQ);
  assign q_busy      = (state_q != ST_IDLE);
  assign q_dbg_state = state_q;

endmodule

// File: tb/tb_prco_lsu.sv
// Randomized bench for prco_lsu: each operation is issued from IDLE, a RAM
// responder acks after a chosen latency, and observed events are scoreboarded.
module tb_prco_lsu;
  import prco_lsu_pkg::*;

  localparam int TMO = 4;
  localparam int EW  = 29;
  localparam logic [1:0] EV_WB = 2'd1, EV_BR = 2'd2, EV_FLT = 2'd3;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ce_ram, i_ce_reg, i_should_branch;
  logic [4:0]  i_op;
  logic [15:0] i_alu_result, i_store_data;
  logic [2:0]  i_rd;
  logic        q_mem_req, q_mem_we;
  logic [15:0] q_mem_addr, q_mem_wdata;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;
  logic        q_wb_en;
  logic [2:0]  q_wb_reg;
  logic [15:0] q_wb_data;
  logic        q_branch;
  logic [15:0] q_branch_target;
  logic        q_busy, q_fault;
  logic [1:0]  q_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];

  prco_lsu #(.DATA_W(16), .REG_SEL_W(3), .MEM_TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce_ram(i_ce_ram), .i_ce_reg(i_ce_reg),
    .i_should_branch(i_should_branch), .i_op(i_op), .i_alu_result(i_alu_result),
    .i_store_data(i_store_data), .i_rd(i_rd), .q_mem_req(q_mem_req),
    .q_mem_we(q_mem_we), .q_mem_addr(q_mem_addr), .q_mem_wdata(q_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .q_wb_en(q_wb_en),
    .q_wb_reg(q_wb_reg), .q_wb_data(q_wb_data), .q_branch(q_branch),
    .q_branch_target(q_branch_target), .q_busy(q_busy), .q_fault(q_fault),
    .q_dbg_state(q_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic [1:0] kind, input int cyc,
                                       input logic [2:0] rg, input logic [15:0] data);
    return {kind, 8'(cyc), rg, data};
  endfunction

  task automatic clear_inputs();
    i_ce_ram = 0; i_ce_reg = 0; i_should_branch = 0; i_op = PRCO_OP_NOP;
    i_alu_result = 0; i_store_data = 0; i_rd = 0;
  endtask

  // driver + reference model for one operation accepted from IDLE
  task automatic run_op(input logic ce_ram, input logic ce_reg, input logic br,
                        input logic [4:0] op, input logic [15:0] alu,
                        input logic [15:0] sdata, input logic [2:0] rd,
                        input int lat, input logic [15:0] rdata);
    int exp_busy, obs_busy;
    logic store;
    exp_q.delete();
    obs_q.delete();
    store = (op == PRCO_OP_SW);
    if (ce_ram) begin
      if (lat <= TMO) begin
        exp_busy = store ? lat : lat + 1;
        if (!store) exp_q.push_back(ev(EV_WB, lat + 1, rd, rdata));
      end else begin
        exp_busy = TMO;
        exp_q.push_back(ev(EV_FLT, TMO + 1, 3'd0, 16'd0));
      end
    end else begin
      exp_busy = 0;
      if (ce_reg && !(op inside {PRCO_OP_NOP, PRCO_OP_CMP, PRCO_OP_JMP, PRCO_OP_SW}))
        exp_q.push_back(ev(EV_WB, 1, rd, alu));
      if (br) exp_q.push_back(ev(EV_BR, 1, 3'd0, alu));
    end

    @(negedge i_clk);
    i_ce_ram = ce_ram; i_ce_reg = ce_reg; i_should_branch = br; i_op = op;
    i_alu_result = alu; i_store_data = sdata; i_rd = rd;
    obs_busy = 0;
    for (int k = 1; k <= TMO + 4; k++) begin
      @(posedge i_clk);
      #1;
      if (k == 1) begin
        clear_inputs();
        chk("req_start", q_mem_req, ce_ram);
        if (ce_ram) begin
          chk("mem_addr", q_mem_addr, alu);
          chk("mem_we", q_mem_we, store);
          if (store) chk("mem_wdata", q_mem_wdata, sdata);
        end
      end
      if (ce_ram && k == lat && lat <= TMO) begin
        chk("addr_hold", q_mem_addr, alu);
        chk("req_hold", q_mem_req, 1'b1);
      end
      if (q_busy) obs_busy++;
      if (q_wb_en)  obs_q.push_back(ev(EV_WB, k, q_wb_reg, q_wb_data));
      if (q_branch) obs_q.push_back(ev(EV_BR, k, 3'd0, q_branch_target));
      if (q_fault)  obs_q.push_back(ev(EV_FLT, k, 3'd0, 16'd0));
      i_mem_ack   = ce_ram && (k == lat) && (lat <= TMO);
      i_mem_rdata = i_mem_ack ? rdata : 16'($urandom);
    end
    chk("busy_cycles", obs_busy, exp_busy);
    chk("event_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk("event", obs_q[i], exp_q[i]);
    chk("end_idle", q_dbg_state, 2'd0);
  endtask

  initial begin
    logic [4:0] ops [10];
    ops = '{PRCO_OP_NOP, PRCO_OP_ADD, PRCO_OP_SUB, PRCO_OP_AND, PRCO_OP_OR,
            PRCO_OP_XOR, PRCO_OP_CMP, PRCO_OP_JMP, PRCO_OP_LW, PRCO_OP_SW};
    clear_inputs();
    i_mem_ack = 0; i_mem_rdata = 0;
    i_rst_n = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_outputs",
        {q_mem_req, q_mem_we, q_mem_addr, q_wb_en, q_wb_reg, q_branch, q_busy, q_fault},
        32'd0);
    chk("reset_data", {q_wb_data, q_branch_target}, 32'd0);
    chk("reset_state", q_dbg_state, 2'd0);
    @(negedge i_clk);
    i_rst_n = 1;

    // directed cases
    run_op(0, 1, 0, PRCO_OP_ADD, 16'h1234, 16'h0, 3'd3, 0, 16'h0);
    run_op(1, 0, 0, PRCO_OP_LW, 16'h0040, 16'h0, 3'd5, 3, 16'hBEEF);
    run_op(1, 0, 0, PRCO_OP_SW, 16'h0010, 16'h00AA, 3'd1, 1, 16'h0);
    run_op(0, 1, 1, PRCO_OP_JMP, 16'h0020, 16'h0, 3'd2, 0, 16'h0);
    run_op(1, 0, 0, PRCO_OP_LW, 16'h0080, 16'h0, 3'd4, TMO + 1, 16'h0);
    run_op(1, 0, 0, PRCO_OP_LW, 16'h0044, 16'h0, 3'd6, TMO, 16'hCAFE);
    run_op(1, 1, 1, PRCO_OP_ADD, 16'h0050, 16'h0, 3'd7, 2, 16'h5A5A);

    // reset in the middle of an outstanding load
    @(negedge i_clk);
    i_ce_ram = 1; i_op = PRCO_OP_LW; i_alu_result = 16'h0060; i_rd = 3'd2;
    @(posedge i_clk);
    #1;
    clear_inputs();
    @(posedge i_clk);
    #1;
    chk("pre_reset_req", q_mem_req, 1'b1);
    i_rst_n = 0;
    #1;
    chk("async_reset", {q_mem_req, q_busy, q_wb_en, q_fault}, 4'd0);
    chk("async_reset_state", q_dbg_state, 2'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1;
    run_op(1, 0, 0, PRCO_OP_LW, 16'h0062, 16'h0, 3'd3, 2, 16'h7777);

    // randomized operations
    for (int n = 0; n < 80; n++) begin
      run_op($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
             ops[$urandom_range(0, 9)], 16'($urandom), 16'($urandom),
             3'($urandom), $urandom_range(1, TMO + 1), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
